// File: rtl/pcie_tx_scrambler_if.sv
// Symbol stream bundle for the PCIe transmit scrambler: upstream input side, downstream
// output side and the LFSR debug tap.
interface pcie_tx_scrambler_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  in_data_i;
    logic        in_k_i;
    logic        scr_disable_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic        out_k_o;
    logic [15:0] lfsr_o;

    modport slave (
        input  in_valid_i, in_data_i, in_k_i, scr_disable_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_k_o, lfsr_o
    );

    modport master (
        output in_valid_i, in_data_i, in_k_i, scr_disable_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_k_o, lfsr_o
    );
endinterface

// File: rtl/pcie_tx_scrambler.sv
// Gen1/Gen2 PCIe transmit scrambler: Galois LFSR x^16+x^5+x^4+x^3+1, one symbol per cycle,
// output register plus one skid register.
module pcie_tx_scrambler #(
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input logic                  clk_i,
    input logic                  rst_i,
    pcie_tx_scrambler_if.slave   bus
);

    localparam logic [7:0] ComByte = 8'hBC;
    localparam logic [7:0] SkpByte = 8'h1C;

    logic        or_valid_q, or_valid_d;
    logic [7:0]  or_data_q, or_data_d;
    logic        or_k_q, or_k_d;
    logic        sk_valid_q, sk_valid_d;
    logic [7:0]  sk_data_q, sk_data_d;
    logic        sk_k_q, sk_k_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        in_ready_q;

    logic        accept;
    logic        drain;
    logic        is_com;
    logic        is_skp;
    logic        scramble_en;
    logic [15:0] lfsr_step;
    logic [7:0]  sym_data;

    assign accept      = bus.in_valid_i && in_ready_q;
    assign drain       = or_valid_q && bus.out_ready_i;
    assign is_com      = bus.in_k_i && (bus.in_data_i == ComByte);
    assign is_skp      = bus.in_k_i && (bus.in_data_i == SkpByte);
    assign scramble_en = !bus.in_k_i && !bus.scr_disable_i;

    // Eight serial Galois steps unrolled; data bit i is XORed with the feedback of step i.
    always_comb begin
        lfsr_step = lfsr_q;
        sym_data  = bus.in_data_i;
        for (int i = 0; i < 8; i++) begin
            if (lfsr_step[15] && scramble_en) begin
                sym_data[i] = ~sym_data[i];
            end
            lfsr_step = {lfsr_step[14:0], 1'b0} ^ (lfsr_step[15] ? 16'h0039 : 16'h0000);
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            if (is_com) begin
                lfsr_d = SEED;
            end else if (!is_skp) begin
                lfsr_d = lfsr_step;
            end
        end
    end

    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_k_d     = or_k_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        sk_k_d     = sk_k_q;
        if (drain && sk_valid_q) begin
            // in_ready is low whenever SK is full, so no accept can collide here.
            or_data_d  = sk_data_q;
            or_k_d     = sk_k_q;
            sk_valid_d = 1'b0;
        end else if (drain || !or_valid_q) begin
            or_valid_d = accept;
            if (accept) begin
                or_data_d = sym_data;
                or_k_d    = bus.in_k_i;
            end
        end else if (accept) begin
            sk_valid_d = 1'b1;
            sk_data_d  = sym_data;
            sk_k_d     = bus.in_k_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            or_valid_q <= 1'b0;
            or_data_q  <= 8'h00;
            or_k_q     <= 1'b0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= 8'h00;
            sk_k_q     <= 1'b0;
            lfsr_q     <= SEED;
            in_ready_q <= 1'b0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_k_q     <= or_k_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
            sk_k_q     <= sk_k_d;
            lfsr_q     <= lfsr_d;
            in_ready_q <= !sk_valid_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = or_valid_q;
    assign bus.out_data_o  = or_data_q;
    assign bus.out_k_o     = or_k_q;
    assign bus.lfsr_o      = lfsr_q;

endmodule

// File: tb/tb_pcie_tx_scrambler.sv
// Directed bench for pcie_tx_scrambler: known scrambler vectors, SKP/bypass handling,
// backpressure, mid-stream reset and a randomised handshake run against a small model.
module tb_pcie_tx_scrambler;

    localparam logic [15:0] Seed = 16'hFFFF;

    logic clk;
    logic rst;
    pcie_tx_scrambler_if bus ();

    pcie_tx_scrambler #(.SEED(Seed)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] m_lfsr;
    bit          rand_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the expected stream on every transfer, checks stall stability.
    logic       prev_stall = 1'b0;
    logic [8:0] prev_sym   = '0;
    always @(posedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid_o === 1'b1) begin
                check("stall_hold", {23'd0, bus.out_k_o, bus.out_data_o}, {23'd0, prev_sym});
            end
            if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", {23'd0, bus.out_k_o, bus.out_data_o}, 32'h1ff);
                end else begin
                    check("out_sym", {23'd0, bus.out_k_o, bus.out_data_o},
                          {23'd0, exp_q.pop_front()});
                end
            end
            prev_stall = (bus.out_valid_o === 1'b1) && (bus.out_ready_i !== 1'b1);
            prev_sym   = {bus.out_k_o, bus.out_data_o};
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_mode) bus.out_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_sym(input logic k, input logic [7:0] d);
        exp_q.push_back({k, d});
    endtask

    task automatic model_push(input logic [7:0] d, input logic k, input logic dis);
        logic [7:0]  o = d;
        logic [15:0] l = m_lfsr;
        if (k && d == 8'hBC) begin
            l = Seed;
        end else if (!(k && d == 8'h1C)) begin
            for (int i = 0; i < 8; i++) begin
                if (l[15] && !k && !dis) o[i] = ~o[i];
                l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
            end
        end
        m_lfsr = l;
        exp_q.push_back({k, o});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid low.
    task automatic send(input logic [7:0] d, input logic k, input logic dis, input bit mdl);
        int n = 0;
        bus.in_valid_i    = 1'b1;
        bus.in_data_i     = d;
        bus.in_k_i        = k;
        bus.scr_disable_i = dis;
        while (bus.in_ready_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            check("ready_timeout", 32'd0, 32'd1);
            bus.in_valid_i = 1'b0;
            return;
        end
        if (mdl) model_push(d, k, dis);
        tick();
        bus.in_valid_i = 1'b0;
        if (mdl) check("lfsr_model", {16'd0, bus.lfsr_o}, {16'd0, m_lfsr});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    logic [7:0] vec1 [16] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82,
                              8'h72, 8'h6E, 8'h28, 8'hA6, 8'hBE, 8'h6D, 8'hBF, 8'h8D};
    logic [7:0] bp_exp [5] = '{8'hBC, 8'hFF, 8'h17, 8'hC0, 8'h14};

    initial begin
        int idx;
        rst               = 1'b1;
        bus.in_valid_i    = 1'b0;
        bus.in_data_i     = 8'h00;
        bus.in_k_i        = 1'b0;
        bus.scr_disable_i = 1'b0;
        bus.out_ready_i   = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst_out_data", {24'd0, bus.out_data_o}, 32'd0);
        check("rst_out_k", {31'd0, bus.out_k_o}, 32'd0);
        check("rst_lfsr", {16'd0, bus.lfsr_o}, 32'hFFFF);
        check("rst_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, bus.in_ready_o}, 32'd1);

        // COM followed by 16 zero bytes: the reference scrambler sequence.
        bus.out_ready_i = 1'b1;
        expect_sym(1'b1, 8'hBC);
        for (int i = 0; i < 16; i++) expect_sym(1'b0, vec1[i]);
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        check("com_lfsr", {16'd0, bus.lfsr_o}, 32'hFFFF);
        for (int i = 0; i < 16; i++) send(8'h00, 1'b0, 1'b0, 1'b0);
        drain();

        // SKP must not advance the LFSR.
        expect_sym(1'b1, 8'hBC);
        expect_sym(1'b0, 8'hFF);
        expect_sym(1'b1, 8'h1C);
        expect_sym(1'b0, 8'h17);
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        check("com2_lfsr", {16'd0, bus.lfsr_o}, 32'hFFFF);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        check("pre_skp_lfsr", {16'd0, bus.lfsr_o}, 32'hE817);
        send(8'h1C, 1'b1, 1'b0, 1'b0);
        check("post_skp_lfsr", {16'd0, bus.lfsr_o}, 32'hE817);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        drain();

        // Bypass still advances the LFSR.
        expect_sym(1'b1, 8'hBC);
        expect_sym(1'b0, 8'hA5);
        expect_sym(1'b0, 8'h17);
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        check("bypass_lfsr", {16'd0, bus.lfsr_o}, 32'hE817);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: five symbols offered, only two taken.
        bus.out_ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid_i = 1'b1;
            bus.in_k_i     = (idx == 0);
            bus.in_data_i  = (idx == 0) ? 8'hBC : 8'h00;
            if (bus.in_ready_o === 1'b1) begin
                expect_sym(idx == 0, bp_exp[idx]);
                idx++;
            end
            tick();
        end
        bus.in_valid_i = 1'b0;
        check("bp_accepted", idx, 32'd2);
        check("bp_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
        check("bp_out_valid", {31'd0, bus.out_valid_o}, 32'd1);
        bus.out_ready_i = 1'b1;
        for (int i = 2; i < 5; i++) begin
            expect_sym(1'b0, bp_exp[i]);
            send(8'h00, 1'b0, 1'b0, 1'b0);
        end
        drain();

        // Randomised valid/ready against the model.
        m_lfsr    = 16'h0000;
        rand_mode = 1'b1;
        send(8'hBC, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            logic       k;
            int         sel;
            while ($urandom_range(0, 1) == 0) tick();
            sel = int'($urandom_range(0, 19));
            d   = 8'($urandom);
            k   = 1'b0;
            if (sel == 0) begin
                k = 1'b1; d = 8'hBC;
            end else if (sel == 1) begin
                k = 1'b1; d = 8'h1C;
            end else if (sel == 2) begin
                k = 1'b1; d = 8'hF7;
            end
            send(d, k, 1'($urandom_range(0, 7) == 0), 1'b1);
        end
        rand_mode       = 1'b0;
        bus.out_ready_i = 1'b1;
        drain();

        // Mid-stream reset with two symbols buffered; inputs during reset are ignored.
        bus.out_ready_i = 1'b0;
        expect_sym(1'b1, 8'hBC);
        expect_sym(1'b0, 8'hFF);
        send(8'hBC, 1'b1, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        rst               = 1'b1;
        bus.in_valid_i    = 1'b1;
        bus.in_k_i        = 1'b0;
        bus.in_data_i     = 8'h55;
        tick();
        check("midrst_out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("midrst_lfsr", {16'd0, bus.lfsr_o}, 32'hFFFF);
        exp_q.delete();
        tick();
        check("midrst_lfsr_hold", {16'd0, bus.lfsr_o}, 32'hFFFF);
        rst             = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        tick();
        expect_sym(1'b0, 8'hFF);
        send(8'h00, 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
